// File: rtl/sobel_edge_detect_pkg.sv
// rtl/sobel_edge_detect_pkg.sv - shared image-pipeline constants and sync-edge helper
package sobel_edge_detect_pkg;

  localparam int DATA_W  = 8;
  localparam int MAG_W   = DATA_W + 3;
  localparam int CNT_W   = 20;
  localparam int LATENCY = 3;

  typedef enum logic [1:0] {
    VS_NONE = 2'b00,
    VS_RISE = 2'b01,
    VS_FALL = 2'b10
  } vs_edge_e;

  function automatic vs_edge_e vs_edge(input logic cur, input logic prev);
    return vs_edge_e'({prev & ~cur, cur & ~prev});
  endfunction

endpackage

// File: rtl/sobel_edge_detect_if.sv
// rtl/sobel_edge_detect_if.sv - 3x3 window tap bus with line/frame syncs
interface sobel_edge_detect_if #(
  parameter int DATA_W = 8
);

  logic              matrix_valid;
  logic [DATA_W-1:0] matrix_p11, matrix_p12, matrix_p13;
  logic [DATA_W-1:0] matrix_p21, matrix_p22, matrix_p23;
  logic [DATA_W-1:0] matrix_p31, matrix_p32, matrix_p33;
  logic              matrix_hs;
  logic              matrix_vs;

  modport master (
    output matrix_valid,
    output matrix_p11, matrix_p12, matrix_p13,
    output matrix_p21, matrix_p22, matrix_p23,
    output matrix_p31, matrix_p32, matrix_p33,
    output matrix_hs, matrix_vs
  );

  modport slave (
    input matrix_valid,
    input matrix_p11, matrix_p12, matrix_p13,
    input matrix_p21, matrix_p22, matrix_p23,
    input matrix_p31, matrix_p32, matrix_p33,
    input matrix_hs, matrix_vs
  );

endinterface

// File: rtl/sobel_grad_axis.sv
// rtl/sobel_grad_axis.sv - one Sobel axis: registered weighted sums, then registered |pos-neg|
module sobel_grad_axis #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pos_a_i,
  input  logic [DATA_W-1:0] pos_b_i,
  input  logic [DATA_W-1:0] pos_c_i,
  input  logic [DATA_W-1:0] neg_a_i,
  input  logic [DATA_W-1:0] neg_b_i,
  input  logic [DATA_W-1:0] neg_c_i,
  output logic [DATA_W+1:0] grad_abs_o
);

  localparam int SUM_W = DATA_W + 2;

  logic [SUM_W-1:0] pos_d, neg_d, pos_q, neg_q;
  logic [SUM_W-1:0] abs_d, abs_q;

  // a + 2b + c fits exactly in DATA_W+2 bits, so both partials stay unsigned
  function automatic logic [SUM_W-1:0] wsum(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    return SUM_W'(a) + (SUM_W'(b) << 1) + SUM_W'(c);
  endfunction

  assign pos_d = wsum(pos_a_i, pos_b_i, pos_c_i);
  assign neg_d = wsum(neg_a_i, neg_b_i, neg_c_i);
  assign abs_d = (pos_q >= neg_q) ? (pos_q - neg_q) : (neg_q - pos_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= '0;
      neg_q <= '0;
      abs_q <= '0;
    end else begin
      pos_q <= pos_d;
      neg_q <= neg_d;
      abs_q <= abs_d;
    end
  end

  assign grad_abs_o = abs_q;

endmodule

// File: rtl/sobel_edge_detect.sv
// rtl/sobel_edge_detect.sv - 3-stage Sobel magnitude, threshold and per-frame edge counter
module sobel_edge_detect #(
  parameter int DATA_W = sobel_edge_detect_pkg::DATA_W,
  parameter int MAG_W  = sobel_edge_detect_pkg::MAG_W,
  parameter int CNT_W  = sobel_edge_detect_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  sobel_edge_detect_if.slave win,
  input  logic [MAG_W-1:0]   thresh,
  output logic               edge_valid,
  output logic [MAG_W-1:0]   edge_mag,
  output logic               edge_bit,
  output logic               edge_hs,
  output logic               edge_vs,
  output logic [CNT_W-1:0]   frame_edge_cnt,
  output logic               cnt_done
);

  import sobel_edge_detect_pkg::*;

  localparam int SUM_W = DATA_W + 2;

  logic [SUM_W-1:0]   gx_abs, gy_abs;
  logic [LATENCY-1:0] valid_q, hs_q, vs_q;
  logic               vs_in_q, edge_vs_q;
  logic [MAG_W-1:0]   thresh_q, thr1_q, thr2_q;
  logic [MAG_W-1:0]   mag_d, mag_q;
  logic               bit_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q, frame_cnt_q;
  logic               done_q;
  logic               inc;
  vs_edge_e           in_edge, out_edge;

  sobel_grad_axis #(.DATA_W(DATA_W)) u_gx (
    .clk        (clk),
    .rst        (rst),
    .pos_a_i    (win.matrix_p13),
    .pos_b_i    (win.matrix_p23),
    .pos_c_i    (win.matrix_p33),
    .neg_a_i    (win.matrix_p11),
    .neg_b_i    (win.matrix_p21),
    .neg_c_i    (win.matrix_p31),
    .grad_abs_o (gx_abs)
  );

  sobel_grad_axis #(.DATA_W(DATA_W)) u_gy (
    .clk        (clk),
    .rst        (rst),
    .pos_a_i    (win.matrix_p31),
    .pos_b_i    (win.matrix_p32),
    .pos_c_i    (win.matrix_p33),
    .neg_a_i    (win.matrix_p11),
    .neg_b_i    (win.matrix_p12),
    .neg_c_i    (win.matrix_p13),
    .grad_abs_o (gy_abs)
  );

  assign in_edge  = vs_edge(win.matrix_vs, vs_in_q);
  assign out_edge = vs_edge(vs_q[LATENCY-1], edge_vs_q);
  assign mag_d    = MAG_W'(gx_abs) + MAG_W'(gy_abs);
  assign inc      = valid_q[LATENCY-1] & bit_q;

  always_comb begin
    cnt_d = cnt_q;
    if (out_edge == VS_RISE) begin
      cnt_d = inc ? CNT_W'(1) : '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // The threshold travels with the pixels so the last pixels of a frame still
  // compare against that frame's value when the next frame starts right after.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      hs_q        <= '0;
      vs_q        <= '0;
      vs_in_q     <= 1'b0;
      edge_vs_q   <= 1'b0;
      thresh_q    <= '0;
      thr1_q      <= '0;
      thr2_q      <= '0;
      mag_q       <= '0;
      bit_q       <= 1'b0;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      valid_q   <= {valid_q[LATENCY-2:0], win.matrix_valid};
      hs_q      <= {hs_q[LATENCY-2:0], win.matrix_hs};
      vs_q      <= {vs_q[LATENCY-2:0], win.matrix_vs};
      vs_in_q   <= win.matrix_vs;
      edge_vs_q <= vs_q[LATENCY-1];
      if (in_edge == VS_RISE) begin
        thresh_q <= thresh;
      end
      thr1_q <= (in_edge == VS_RISE) ? thresh : thresh_q;
      thr2_q <= thr1_q;
      mag_q  <= valid_q[LATENCY-2] ? mag_d : '0;
      bit_q  <= valid_q[LATENCY-2] && (mag_d > thr2_q);
      cnt_q  <= cnt_d;
      done_q <= (out_edge == VS_FALL);
      if (out_edge == VS_FALL) begin
        frame_cnt_q <= cnt_q;
      end
    end
  end

  assign edge_valid     = valid_q[LATENCY-1];
  assign edge_hs        = hs_q[LATENCY-1];
  assign edge_vs        = vs_q[LATENCY-1];
  assign edge_mag       = mag_q;
  assign edge_bit       = bit_q;
  assign frame_edge_cnt = frame_cnt_q;
  assign cnt_done       = done_q;

endmodule

// File: tb/tb_sobel_edge_detect.sv
// tb/tb_sobel_edge_detect.sv - vector table, corner sequences and random frames against a Sobel model
module tb_sobel_edge_detect;

  import sobel_edge_detect_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [MAG_W-1:0] thresh;
  logic             edge_valid, edge_bit, edge_hs, edge_vs, cnt_done;
  logic [MAG_W-1:0] edge_mag;
  logic [CNT_W-1:0] frame_edge_cnt;
  logic             s_valid, s_bit, s_hs, s_vs, s_cnt_done;
  logic [MAG_W-1:0] s_mag;
  logic [2:0]       s_frame_edge_cnt;

  sobel_edge_detect_if #(.DATA_W(DATA_W)) win ();

  sobel_edge_detect dut (
    .clk(clk), .rst(rst), .win(win.slave), .thresh(thresh),
    .edge_valid(edge_valid), .edge_mag(edge_mag), .edge_bit(edge_bit),
    .edge_hs(edge_hs), .edge_vs(edge_vs),
    .frame_edge_cnt(frame_edge_cnt), .cnt_done(cnt_done)
  );

  sobel_edge_detect #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .win(win.slave), .thresh(thresh),
    .edge_valid(s_valid), .edge_mag(s_mag), .edge_bit(s_bit),
    .edge_hs(s_hs), .edge_vs(s_vs),
    .frame_edge_cnt(s_frame_edge_cnt), .cnt_done(s_cnt_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int valid;
    int hs;
    int vs;
    int mag;
    int ebit;
    int fall;
  } exp_t;

  typedef struct {
    int    t[9];
    int    thr;
    int    mag;
    int    ebit;
    string name;
  } vec_t;

  exp_t  exp_q[$];
  vec_t  tbl[8];
  int    tap[9];
  int    checks = 0, errors = 0;
  int    cur_thr = 0, prev_vs = 0, frame_cnt = 0, pending = -1;
  int    done_seen = 0, last_cnt = 0, last_s_cnt = 0, bits_seen = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Sobel magnitude straight from the kernel definitions; index = 3*(row-1)+(col-1)
  function automatic int sobel_mag(input int t[9]);
    int gx, gy;
    gx = (t[2] + 2 * t[5] + t[8]) - (t[0] + 2 * t[3] + t[6]);
    gy = (t[6] + 2 * t[7] + t[8]) - (t[0] + 2 * t[1] + t[2]);
    return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
  endfunction

  task automatic cyc(input int v, input int hs, input int vs);
    exp_t e;
    int   m;
    win.matrix_valid = v[0];
    win.matrix_hs    = hs[0];
    win.matrix_vs    = vs[0];
    win.matrix_p11 = DATA_W'(tap[0]); win.matrix_p12 = DATA_W'(tap[1]); win.matrix_p13 = DATA_W'(tap[2]);
    win.matrix_p21 = DATA_W'(tap[3]); win.matrix_p22 = DATA_W'(tap[4]); win.matrix_p23 = DATA_W'(tap[5]);
    win.matrix_p31 = DATA_W'(tap[6]); win.matrix_p32 = DATA_W'(tap[7]); win.matrix_p33 = DATA_W'(tap[8]);
    e.fall = (!vs && prev_vs) ? frame_cnt : -1;
    if (vs && !prev_vs) begin
      cur_thr   = int'(thresh);
      frame_cnt = 0;
    end
    m      = sobel_mag(tap);
    e.valid = v;
    e.hs    = hs;
    e.vs    = vs;
    e.mag   = v ? m : 0;
    e.ebit  = (v && m > cur_thr) ? 1 : 0;
    if (vs && e.ebit) frame_cnt++;
    prev_vs = vs;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      check("edge_valid", edge_valid, e.valid);
      check("edge_mag", edge_mag, e.mag);
      check("edge_bit", edge_bit, e.ebit);
      check("edge_hs", edge_hs, e.hs);
      check("edge_vs", edge_vs, e.vs);
      check("cnt_done", cnt_done, pending >= 0);
      check("sat_cnt_done", s_cnt_done, pending >= 0);
      if (pending >= 0) begin
        check("frame_edge_cnt", frame_edge_cnt, pending);
        check("sat_frame_edge_cnt", s_frame_edge_cnt, pending > 7 ? 7 : pending);
      end
      pending = e.fall;
    end
    if (cnt_done) begin
      done_seen++;
      last_cnt   = int'(frame_edge_cnt);
      last_s_cnt = int'(s_frame_edge_cnt);
    end
    if (edge_bit) bits_seen++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("reset_outputs_zero",
            |{edge_valid, edge_mag, edge_bit, edge_hs, edge_vs, frame_edge_cnt, cnt_done,
              s_valid, s_mag, s_bit, s_hs, s_vs, s_frame_edge_cnt, s_cnt_done}, 0);
    end
    rst = 1'b0;
    exp_q.delete();
    pending   = -1;
    prev_vs   = 0;
    cur_thr   = 0;
    frame_cnt = 0;
  endtask

  task automatic set_all(input int val);
    for (int i = 0; i < 9; i++) tap[i] = val;
  endtask

  task automatic set_vstep();
    for (int i = 0; i < 9; i++) tap[i] = (i % 3 == 0) ? 0 : ((i % 3 == 1) ? 128 : 255);
  endtask

  task automatic rand_taps();
    int mode, a, b;
    mode = $urandom_range(0, 2);
    a    = $urandom_range(0, 255);
    b    = $urandom_range(0, 255);
    for (int i = 0; i < 9; i++) begin
      if (mode == 0)      tap[i] = $urandom_range(0, 255);
      else if (mode == 1) tap[i] = (i % 3 == 2) ? a : b;
      else                tap[i] = (i / 3 == 0) ? a : b;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  initial begin
    int d0, len, gap;
    rst    = 1'b1;
    thresh = '0;
    set_all(0);
    win.matrix_valid = 1'b0; win.matrix_hs = 1'b0; win.matrix_vs = 1'b0;
    win.matrix_p11 = '0; win.matrix_p12 = '0; win.matrix_p13 = '0;
    win.matrix_p21 = '0; win.matrix_p22 = '0; win.matrix_p23 = '0;
    win.matrix_p31 = '0; win.matrix_p32 = '0; win.matrix_p33 = '0;
    do_reset(2);

    tbl[0] = '{t:'{100, 100, 100, 100, 100, 100, 100, 100, 100}, thr:0,    mag:0,    ebit:0, name:"flat"};
    tbl[1] = '{t:'{0, 128, 255, 0, 128, 255, 0, 128, 255},       thr:100,  mag:1020, ebit:1, name:"vstep"};
    tbl[2] = '{t:'{0, 0, 0, 0, 0, 255, 0, 255, 255},             thr:1530, mag:1530, ebit:0, name:"diag_eq"};
    tbl[3] = '{t:'{0, 0, 0, 0, 0, 255, 0, 255, 255},             thr:1529, mag:1530, ebit:1, name:"diag_below"};
    tbl[4] = '{t:'{255, 255, 0, 255, 0, 0, 0, 0, 0},             thr:1000, mag:1530, ebit:1, name:"diag_neg"};
    tbl[5] = '{t:'{255, 255, 255, 0, 0, 0, 0, 0, 0},             thr:1020, mag:1020, ebit:0, name:"hstep_eq"};
    tbl[6] = '{t:'{0, 0, 0, 0, 255, 0, 0, 0, 0},                 thr:0,    mag:0,    ebit:0, name:"center"};
    tbl[7] = '{t:'{0, 255, 0, 0, 0, 0, 0, 0, 0},                 thr:509,  mag:510,  ebit:1, name:"p12_only"};

    for (int i = 0; i < 8; i++) begin
      thresh = MAG_W'(tbl[i].thr);
      tap    = tbl[i].t;
      cyc(1, 0, 1);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      check({tbl[i].name, "_valid"}, edge_valid, 1);
      check({tbl[i].name, "_mag"}, edge_mag, tbl[i].mag);
      check({tbl[i].name, "_bit"}, edge_bit, tbl[i].ebit);
      cyc(0, 0, 0);
    end
    idle(3);

    // flat window held for 10 cycles: first valid output exactly 3 cycles in
    thresh = '0;
    set_all(100);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 1);
      if (i < 3) check("flat_latency_valid", edge_valid, i == 2);
      else       check("flat_mag_zero", edge_mag, 0);
    end
    idle(4);

    // mid-frame threshold change only lands on the next frame
    set_vstep();
    thresh    = MAG_W'(2040);
    bits_seen = 0;
    cyc(1, 0, 1);
    thresh = '0;
    for (int i = 0; i < 5; i++) cyc(1, 0, 1);
    idle(4);
    check("thresh_hold_bits", bits_seen, 0);
    bits_seen = 0;
    for (int i = 0; i < 3; i++) cyc(1, 0, 1);
    idle(4);
    check("thresh_next_frame_bits", bits_seen, 3);

    // 20-pixel frame with 7 edges
    thresh = MAG_W'(100);
    d0     = done_seen;
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0) set_vstep();
      else            set_all(100);
      cyc(1, 0, 1);
    end
    idle(6);
    check("frame20_done_pulses", done_seen - d0, 1);
    check("frame20_cnt", last_cnt, 7);

    // 12 edges overflow the 3-bit counter, back-to-back frames across a one-cycle gap
    set_vstep();
    d0 = done_seen;
    for (int i = 0; i < 12; i++) cyc(1, 0, 1);
    cyc(0, 0, 0);
    for (int i = 0; i < 2; i++) cyc(1, 0, 1);
    idle(6);
    check("b2b_done_pulses", done_seen - d0, 2);
    check("b2b_second_cnt", last_cnt, 2);

    set_vstep();
    for (int i = 0; i < 12; i++) cyc(1, 0, 1);
    idle(6);
    check("sat_wide_cnt", last_cnt, 12);
    check("sat_narrow_cnt", last_s_cnt, 7);

    // reset mid-burst discards the frame in flight
    d0 = done_seen;
    for (int i = 0; i < 5; i++) cyc(1, 1, 1);
    do_reset(1);
    idle(8);
    check("abort_no_done", done_seen - d0, 0);

    for (int f = 0; f < 40; f++) begin
      thresh = MAG_W'($urandom_range(0, 1530));
      len    = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        rand_taps();
        cyc($urandom_range(0, 9) < 8, $urandom_range(0, 1), 1);
        if ($urandom_range(0, 3) == 0) thresh = MAG_W'($urandom_range(0, 1530));
      end
      gap = $urandom_range(1, 3);
      for (int j = 0; j < gap; j++) begin
        rand_taps();
        cyc($urandom_range(0, 3) == 0, 0, 0);
      end
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
